imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_WIDTH, default 12, sets the instruction-memory word address width.
REQ-002 Parameter: TIMEOUT, default 65535, sets the maximum idle cycles allowed between accepted bytes while a load is in progress.
REQ-003 Port: clock, input, 1, the single clock; all state updates on the rising edge.
REQ-004 Port: reset, input, 1, asynchronous, active-low reset.
REQ-005 Port: start, input, 1, single-cycle request to begin a load.
REQ-006 Port: byte_valid, input, 1, byte_data holds a valid byte.
REQ-007 Port: byte_data, input, 8, serial-link payload byte.
REQ-008 Port: byte_ready, output, 1, loader can accept a byte this cycle.
REQ-009 Port: imem_wEn, output, 1, instruction-memory write strobe.
REQ-010 Port: imem_addr, output, ADDR_WIDTH, instruction-memory word address.
REQ-011 Port: imem_dataIn, output, 32, instruction word to write.
REQ-012 Port: cpu_hold, output, 1, active-high; drives the processor's active-high reset.
REQ-013 Port: done, output, 1, the load completed with a good checksum.
REQ-014 Port: error, output, 1, the load failed.

Function
REQ-015 The loader SHALL use a byte handshake in which a byte transfers on a rising edge where byte_valid=1 and byte_ready=1; byte_data is ignored otherwise.
REQ-016 The loader SHALL implement the states IDLE, HDR0, HDR1, LOAD, WRITE, CHECK, DONE and ERROR.
REQ-017 byte_ready SHALL be 1 only in HDR0, HDR1, LOAD and CHECK.
REQ-018 IDLE/DONE/ERROR + start=1 SHALL go to HDR0; it SHALL set cpu_hold=1, clear done and error, and zero imem_addr, the byte counter, the checksum and the timeout counter.
REQ-019 start SHALL be ignored in HDR0, HDR1, LOAD, WRITE and CHECK.
REQ-020 HDR0 SHALL accept count[15:8]; HDR1 SHALL accept count[7:0], giving the word count N.
REQ-021 After HDR1, N=0 or N>2^ADDR_WIDTH SHALL go to ERROR; otherwise the next state SHALL be LOAD.
REQ-022 In LOAD, the loader SHALL accept 4 bytes big-endian (the first byte is bits [31:24]) and assemble them into imem_dataIn.
REQ-023 The edge that accepts the 4th byte SHALL enter WRITE.
REQ-024 WRITE SHALL last exactly one cycle with imem_wEn=1; imem_addr and imem_dataIn SHALL be stable for that cycle.
REQ-025 Write latency: 4th byte accepted at edge k -> imem_wEn high from edge k to edge k+1.
REQ-026 At the end of WRITE, imem_addr SHALL increment by 1; the next state SHALL be LOAD if words written < N, else CHECK.
REQ-027 imem_addr SHALL never wrap during a valid load (N≤2^ADDR_WIDTH); after the last word of N=2^ADDR_WIDTH it SHALL hold its final value rather than wrap.
REQ-028 The checksum SHALL be the 8-bit XOR of all 4N payload bytes; header bytes SHALL be excluded.
REQ-029 CHECK SHALL accept one byte; if it equals the checksum the next state SHALL be DONE, else ERROR.
REQ-030 DONE SHALL set done=1 and cpu_hold=0, both registered, changing on the edge that enters DONE.
REQ-031 ERROR SHALL set error=1 and keep cpu_hold=1.
REQ-032 The timeout counter SHALL count cycles in HDR0/HDR1/LOAD/CHECK with no accepted byte and clear on each accepted byte; reaching TIMEOUT SHALL go to ERROR.
REQ-033 A byte offered simultaneously with the timeout-expiry edge SHALL be accepted and SHALL cancel the timeout.
REQ-034 imem_wEn SHALL be 0 in every state except WRITE; no partial word SHALL ever be written.
REQ-035 A load aborted by timeout or count error SHALL leave words already written untouched and SHALL NOT write any further word.

Reset
REQ-036 reset=0 SHALL immediately (asynchronously) force IDLE, cpu_hold=1, imem_wEn=0, byte_ready=0, done=0, error=0, imem_addr=0 and imem_dataIn=0.
REQ-037 Reset asserted mid-WRITE SHALL drop imem_wEn in the same instant; after reset release the loader SHALL remain in IDLE until start.

Verification
REQ-038 start; bytes 00 01 DE AD BE EF 22 -> one imem_wEn pulse with addr 0 and data 0xDEADBEEF, then done=1, cpu_hold=0, error=0.
REQ-039 N=3 with words 0x00000001, 0x00000002, 0x00000003 and checksum 0x00 -> writes at addr 0, 1 and 2 in order, then done=1.
REQ-040 Header 00 00 -> error=1, cpu_hold=1, no imem_wEn; header 10 01 (N=4097) -> error=1.
REQ-041 Valid N=1 with a checksum byte of 0x23 instead of 0x22 -> word written, then error=1, done=0, cpu_hold=1.
REQ-042 TIMEOUT=16; stall after 2 payload bytes -> error=1 at the 16th idle cycle; no write; a byte arriving on the expiry edge instead continues the load.
REQ-043 Reset pulse during LOAD of word 2 of 3 -> IDLE, cpu_hold=1; a subsequent start and full reload completes with done=1.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed image over a byte
// stream and writes it word by word into instruction memory while holding the CPU in reset.
module imem_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_wEn,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_dataIn,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    LOAD  = 3'd3,
    WRITE = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6,
    ERROR = 3'd7
  } state_t;

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [32:0]   NMAX  = 33'd1 << ADDR_WIDTH;

  state_t        state;
  logic [7:0]    cnt_hi;
  logic [15:0]   n_words;
  logic [15:0]   wcnt;
  logic [1:0]    bcnt;
  logic [7:0]    csum;
  logic [TW-1:0] tcnt;

  logic          accept;
  logic          timeout_hit;
  logic [15:0]   n_full;
  logic          n_bad;
  logic          last_word;
  logic          addr_last;

  // Handshake: a byte moves on a rising edge with byte_valid=1 and
  // byte_ready=1; byte_ready depends only on the state register.
  assign byte_ready  = (state == HDR0) || (state == HDR1) ||
                       (state == LOAD) || (state == CHECK);
  assign imem_wEn    = (state == WRITE);
  assign state_dbg   = state;

  assign accept      = byte_valid && byte_ready;
  assign timeout_hit = byte_ready && !byte_valid && (tcnt == TLAST);
  assign n_full      = {cnt_hi, byte_data};
  assign n_bad       = (n_full == 16'd0) || ({17'd0, n_full} > NMAX);
  assign last_word   = ({1'b0, wcnt} + 17'd1) == {1'b0, n_words};
  assign addr_last   = &imem_addr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt_hi      <= '0;
      n_words     <= '0;
      wcnt        <= '0;
      bcnt        <= '0;
      csum        <= '0;
      tcnt        <= '0;
      imem_addr   <= '0;
      imem_dataIn <= '0;
      cpu_hold    <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      if (byte_ready) begin
        if (accept) tcnt <= '0;
        else        tcnt <= tcnt + 1'b1;
      end

      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state     <= HDR0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            imem_addr <= '0;
            wcnt      <= '0;
            bcnt      <= '0;
            csum      <= '0;
            tcnt      <= '0;
          end
        end

        HDR0: begin
          if (accept) begin
            cnt_hi <= byte_data;
            state  <= HDR1;
          end
        end

        HDR1: begin
          if (accept) begin
            n_words <= n_full;
            if (n_bad) begin
              state <= ERROR;
              error <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end

        LOAD: begin
          if (accept) begin
            imem_dataIn <= {imem_dataIn[23:0], byte_data};
            csum        <= csum ^ byte_data;
            bcnt        <= bcnt + 2'd1;
            if (bcnt == 2'd3) state <= WRITE;
          end
        end

        WRITE: begin
          // Saturate at the top word so a full-memory image never wraps to 0.
          if (!addr_last) imem_addr <= imem_addr + 1'b1;
          wcnt  <= wcnt + 16'd1;
          state <= last_word ? CHECK : LOAD;
        end

        CHECK: begin
          if (accept) begin
            if (byte_data == csum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase

      // Idle-link expiry; an accepted byte on the same edge clears timeout_hit.
      if (timeout_hit) begin
        state    <= ERROR;
        error    <= 1'b1;
        cpu_hold <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a write scoreboard plus end-of-load flag
// checks derived from the image contents.
module tb_imem_loader;
  localparam int AW = 12;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_wEn;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_dataIn;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [2:0]    state_dbg;

  imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_wEn(imem_wEn), .imem_addr(imem_addr), .imem_dataIn(imem_dataIn),
    .cpu_hold(cpu_hold), .done(done), .error(error), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int writes_seen = 0;
  logic [AW+31:0] exp_q[$];
  logic [31:0]    wbuf[$];
  logic [AW-1:0]  last_addr = '0;
  logic [31:0]    last_data = '0;
  logic           prev_wen = 1'b0;
  logic [AW+31:0] e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected (addr, data).
  always @(posedge clock) begin
    #1;
    if (imem_wEn) begin
      writes_seen++;
      chk("wen_single_cycle", prev_wen, 0);
      chk("ready_low_in_write", byte_ready, 0);
      chk("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr", imem_addr, e[AW+31:32]);
        chk("write_data", imem_dataIn, e[31:0]);
      end
      last_addr = imem_addr;
      last_data = imem_dataIn;
    end
    prev_wen = imem_wEn;
  end

  function automatic logic [7:0] model_csum();
    logic [7:0] c = 8'h00;
    foreach (wbuf[i]) c ^= wbuf[i][31:24] ^ wbuf[i][23:16] ^ wbuf[i][15:8] ^ wbuf[i][7:0];
    return c;
  endfunction

  task automatic idle(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit fourth = 1'b0);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("byte_ready_wait", byte_ready, 1);
    @(negedge clock);
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
    if (fourth) chk("wen_latency", imem_wEn, 1);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_ready", byte_ready, 1);
    chk("start_hold", cpu_hold, 1);
    chk("start_done_clr", done, 0);
    chk("start_err_clr", error, 0);
    chk("start_addr", imem_addr, 0);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      send_byte(w[31-8*i -: 8], i == 3);
    end
  endtask

  task automatic end_check(input bit ed, input bit ee);
    chk("done", done, ed);
    chk("error", error, ee);
    chk("cpu_hold", cpu_hold, !ed);
    chk("exp_q_drained", exp_q.size(), 0);
  endtask

  task automatic run_load(input bit bad_csum, input bit gaps, input bit poke);
    int n = wbuf.size();
    logic [7:0] cs = model_csum() ^ (bad_csum ? 8'h01 : 8'h00);
    do_start();
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({AW'(i), wbuf[i]});
      send_word(wbuf[i], gaps);
      if (poke && i == 0) begin
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
    end
    chk("hold_before_check", cpu_hold, 1);
    send_byte(cs);
    end_check(!bad_csum, bad_csum);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    idle(3);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_ready", byte_ready, 0);
    chk("rst_wen", imem_wEn, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_data", imem_dataIn, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset = 1'b1;
    idle(4);
    chk("idle_no_start", byte_ready, 0);

    // Single word DEADBEEF, checksum 0x22.
    wbuf = '{32'hDEADBEEF};
    chk("pin_csum_deadbeef", model_csum(), 8'h22);
    w0 = writes_seen;
    run_load(1'b0, 1'b0, 1'b0);
    chk("pin_one_write", writes_seen - w0, 1);
    chk("pin_last_addr", last_addr, 0);
    chk("pin_last_data", last_data, 32'hDEADBEEF);
    chk("addr_after_1", imem_addr, 1);

    // Three words, checksum 0x00, start pulsed mid-load must be ignored.
    wbuf = '{32'h1, 32'h2, 32'h3};
    chk("pin_csum_123", model_csum(), 8'h00);
    w0 = writes_seen;
    run_load(1'b0, 1'b1, 1'b1);
    chk("pin_three_writes", writes_seen - w0, 3);
    chk("pin_last_addr3", last_addr, 2);
    chk("addr_after_3", imem_addr, 3);

    // Bad counts: N=0 and N=4097.
    do_start(); send_byte(8'h00); send_byte(8'h00);
    end_check(1'b0, 1'b1);
    do_start(); send_byte(8'h10); send_byte(8'h01);
    end_check(1'b0, 1'b1);
    // N=4096 is legal: loader must move on to payload.
    do_start(); send_byte(8'h10); send_byte(8'h00);
    chk("n4096_ready", byte_ready, 1);
    chk("n4096_noerr", error, 0);
    reset = 1'b0; @(negedge clock); reset = 1'b1; idle(2);

    // Wrong checksum 0x23.
    wbuf = '{32'hDEADBEEF};
    w0 = writes_seen;
    run_load(1'b1, 1'b0, 1'b0);
    chk("badcs_write", writes_seen - w0, 1);

    // Stall after 2 payload bytes: error on the 16th idle edge, no write.
    w0 = writes_seen;
    do_start(); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hA1); send_byte(8'hB2);
    idle(TO - 1);
    chk("to_not_yet", error, 0);
    idle(1);
    chk("to_expired", error, 1);
    chk("to_hold", cpu_hold, 1);
    idle(3);
    chk("to_no_write", writes_seen - w0, 0);

    // Byte on the expiry edge keeps the load alive.
    wbuf = '{32'hA1B2C3D4};
    exp_q.push_back({AW'(0), 32'hA1B2C3D4});
    do_start(); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hA1); send_byte(8'hB2);
    idle(TO - 1);
    send_byte(8'hC3);
    chk("to_cancel", error, 0);
    send_byte(8'hD4, 1'b1);
    send_byte(model_csum());
    end_check(1'b1, 1'b0);

    // Reset during word 2 of 3.
    wbuf = '{32'h10, 32'h20, 32'h30};
    exp_q.push_back({AW'(0), 32'h10});
    do_start(); send_byte(8'h00); send_byte(8'h03);
    send_word(32'h10, 1'b0);
    send_byte(8'h00); send_byte(8'h00);
    reset = 1'b0;
    #1;
    chk("mid_rst_hold", cpu_hold, 1);
    chk("mid_rst_ready", byte_ready, 0);
    chk("mid_rst_addr", imem_addr, 0);
    chk("mid_rst_data", imem_dataIn, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clock); reset = 1'b1;
    idle(3);
    chk("post_rst_idle", byte_ready, 0);
    run_load(1'b0, 1'b1, 1'b0);

    // Reset while the write strobe is high drops it at once.
    exp_q.push_back({AW'(0), 32'hCAFEF00D});
    do_start(); send_byte(8'h00); send_byte(8'h01);
    send_word(32'hCAFEF00D, 1'b0);
    reset = 1'b0;
    #1;
    chk("wr_rst_wen", imem_wEn, 0);
    @(negedge clock); reset = 1'b1;
    idle(3);
    chk("wr_rst_q", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
